match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter TURN_TIMEOUT, default 16, the number of COLLECT cycles allowed before missing actions are defaulted.
REQ-002 SHALL have parameter MAX_TURNS, default 32, the number of turns after which the match ends on points.
REQ-003 SHALL have port clk, input, 1, the clock; reset is asynchronous and active-low; the clock is clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a match.
REQ-006 SHALL have port act1_valid, input, 1, player-1 action offer.
REQ-007 SHALL have port act1, input, 3, player-1 action code (kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111).
REQ-008 SHALL have ports act2_valid, input, 1, and act2, input, 3, the same for player 2.
REQ-009 SHALL have ports health1 and health2, input, 2 each, player health fed back from the player blocks.
REQ-010 SHALL have ports act1_ready and act2_ready, output, 1 each, slot open for that player's action.
REQ-011 SHALL have ports action1 and action2, output, 3 each, registered actions driven to the player blocks.
REQ-012 SHALL have port action_enable, output, 1, turn strobe to the player blocks.
REQ-013 SHALL have port game_over, output, 1, match finished.
REQ-014 SHALL have port winner, output, 2: 00 none, 01 player 1, 10 player 2, 11 draw.
REQ-015 SHALL have port turn_count, output, 6, number of completed turns.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE and OVER.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, APPLY, SETTLE, CHECK and OVER.
REQ-018 In IDLE, start SHALL cause a move to COLLECT, clear turn_count and clear the timer; start in any state other than IDLE or OVER SHALL be ignored.
REQ-019 In COLLECT, actN_ready SHALL be high until actN is latched; an action is latched on the first cycle in which actN_valid and actN_ready are both high; further valids SHALL be ignored.
REQ-020 Both players latching in the same cycle SHALL be legal.
REQ-021 COLLECT SHALL move to APPLY on the cycle after both actions are latched.
REQ-022 If TURN_TIMEOUT cycles elapse in COLLECT, each unlatched action SHALL be set to await (010) and the state SHALL move to APPLY.
REQ-023 A valid offer arriving on the timeout cycle SHALL take priority over the await default.
REQ-024 action1 and action2 SHALL hold the latched codes stably from APPLY through CHECK.
REQ-025 action_enable SHALL be high for exactly one cycle, in APPLY, and low in all other states; this guarantees at least one low cycle between turns so the players re-arm.
REQ-026 SETTLE SHALL last one cycle, so that the health updates made by the players at the APPLY edge are visible in CHECK.
REQ-027 In CHECK, turn_count SHALL increment, saturating at 63.
REQ-028 In CHECK, if health1 is 0 and health2 is 0, the result SHALL be draw (11).
REQ-029 In CHECK, if only health1 is 0, player 2 SHALL win (10); if only health2 is 0, player 1 SHALL win (01).
REQ-030 In CHECK, if neither health is 0 and the incremented turn_count equals MAX_TURNS, the player with higher health SHALL win, with equal health giving 11.
REQ-031 In CHECK, when neither REQ-028, REQ-029 nor REQ-030 applies, the state SHALL return to COLLECT.
REQ-032 OVER SHALL hold game_over high and winner stable; start in OVER SHALL restart exactly as from IDLE and clear game_over and winner.

Reset
REQ-033 Reset low SHALL immediately force IDLE, action_enable 0, game_over 0, winner 00, turn_count 0, action1 and action2 await (010), both ready outputs 0, busy 0, and the timer cleared.
REQ-034 Reset mid-turn SHALL discard latched actions without producing an action_enable pulse; operation SHALL resume only on a new start.

Structure
REQ-035 A shared package SHALL hold the action code constants, the winner codes and the state enumeration, reused by the player blocks.
REQ-036 The block SHALL contain one sub-module, turn_timer: a loadable down-counter with clear, enable and an expired flag, sized from TURN_TIMEOUT.

Verification
REQ-037 start, then act1=110 and act2=000 offered in the same cycle -> both latched, action_enable high one cycle two cycles later carrying 110 and 000, turn_count=1.
REQ-038 Only act1 offered, TURN_TIMEOUT=16 -> APPLY at cycle 16 with action2=010 and action1 as offered.
REQ-039 health2 forced to 0 before CHECK -> game_over=1, winner=01; start then clears game_over and winner and restarts at turn 0.
REQ-040 MAX_TURNS=4 with health 3/3 held -> after the fourth CHECK game_over=1, winner=11; with health1=2 and health2=3 -> winner=10.
REQ-041 Reset asserted in COLLECT after one action is latched -> IDLE at once with no action_enable pulse and all outputs at reset values.
REQ-042 Valid held high continuously through a turn -> exactly one latch per turn and action_enable low for at least one cycle between consecutive pulses.

Source files
------------

// File: rtl/match_controller_pkg.sv
// =============================================================================
// Module      : match_controller_pkg
// Description : Action codes, winner codes and controller states shared with
//               the player blocks.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package match_controller_pkg;

    localparam logic [2:0] c_ACT_KICK   = 3'b000;
    localparam logic [2:0] c_ACT_PUNCH  = 3'b001;
    localparam logic [2:0] c_ACT_AWAIT  = 3'b010;
    localparam logic [2:0] c_ACT_JUMP   = 3'b011;
    localparam logic [2:0] c_ACT_LEFT1  = 3'b100;
    localparam logic [2:0] c_ACT_LEFT2  = 3'b101;
    localparam logic [2:0] c_ACT_RIGHT1 = 3'b110;
    localparam logic [2:0] c_ACT_RIGHT2 = 3'b111;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_P1   = 2'b01;
    localparam logic [1:0] c_WIN_P2   = 2'b10;
    localparam logic [1:0] c_WIN_DRAW = 2'b11;

    localparam logic [5:0] c_TURN_COUNT_MAX = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CHECK   = 3'd4,
        ST_OVER    = 3'd5
    } state_e;

    // Outcome when at least one player has been knocked out.
    function automatic logic [1:0] ko_winner(input logic [1:0] h1, input logic [1:0] h2);
        logic [1:0] result;
        result = c_WIN_NONE;
        if (h1 == 2'd0 && h2 == 2'd0) begin
            result = c_WIN_DRAW;
        end else if (h1 == 2'd0) begin
            result = c_WIN_P2;
        end else if (h2 == 2'd0) begin
            result = c_WIN_P1;
        end
        return result;
    endfunction

    // Outcome when the turn limit is reached with both players standing.
    function automatic logic [1:0] points_winner(input logic [1:0] h1, input logic [1:0] h2);
        logic [1:0] result;
        result = c_WIN_DRAW;
        if (h1 > h2) begin
            result = c_WIN_P1;
        end else if (h2 > h1) begin
            result = c_WIN_P2;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/match_controller_timer.sv
// =============================================================================
// Module      : turn_timer
// Description : Loadable down-counter that flags expiry of the action window.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module turn_timer #(
    parameter int TURN_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int                 c_WIDTH      = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [c_WIDTH-1:0] c_LOAD_VALUE = c_WIDTH'(TURN_TIMEOUT - 1);

    logic [c_WIDTH-1:0] count_q;
    logic [c_WIDTH-1:0] count_d;
    logic               armed_q;
    logic               armed_d;

    // Loading with TURN_TIMEOUT-1 makes the TURN_TIMEOUT-th enabled cycle the expiry cycle.
    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        if (clear) begin
            count_d = '0;
            armed_d = 1'b0;
        end else if (load) begin
            count_d = c_LOAD_VALUE;
            armed_d = 1'b1;
        end else if (enable && armed_q && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign expired = armed_q && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/match_controller.sv
// =============================================================================
// Module      : match_controller
// Description : Collects one action per player per turn, strobes them to the
//               player blocks and scores the match from the returned health.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module match_controller
    import match_controller_pkg::*;
#(
    parameter int TURN_TIMEOUT = 16,
    parameter int MAX_TURNS    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       act1_valid,
    input  logic [2:0] act1,
    input  logic       act2_valid,
    input  logic [2:0] act2,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic       act1_ready,
    output logic       act2_ready,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       action_enable,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [5:0] turn_count,
    output logic       busy
);

    state_e     state_q;
    state_e     state_d;
    logic       latched1_q;
    logic       latched1_d;
    logic       latched2_q;
    logic       latched2_d;
    logic [2:0] action1_q;
    logic [2:0] action1_d;
    logic [2:0] action2_q;
    logic [2:0] action2_d;
    logic [5:0] turn_count_q;
    logic [5:0] turn_count_d;
    logic [1:0] winner_q;
    logic [1:0] winner_d;

    logic       w_take1;
    logic       w_take2;
    logic [5:0] w_turn_next;
    logic       w_knockout;
    logic       w_turn_limit;
    logic       w_timer_load;
    logic       w_timer_clear;
    logic       w_timer_enable;
    logic       w_timer_expired;

    assign act1_ready = (state_q == ST_COLLECT) && !latched1_q;
    assign act2_ready = (state_q == ST_COLLECT) && !latched2_q;
    assign w_take1    = act1_ready && act1_valid;
    assign w_take2    = act2_ready && act2_valid;

    assign w_turn_next  = (turn_count_q == c_TURN_COUNT_MAX) ? c_TURN_COUNT_MAX
                                                             : turn_count_q + 6'd1;
    assign w_knockout   = (health1 == 2'd0) || (health2 == 2'd0);
    assign w_turn_limit = (int'(w_turn_next) == MAX_TURNS);

    always_comb begin
        state_d      = state_q;
        latched1_d   = latched1_q;
        latched2_d   = latched2_q;
        action1_d    = action1_q;
        action2_d    = action2_q;
        turn_count_d = turn_count_q;
        winner_d     = winner_q;
        w_timer_load = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d      = ST_COLLECT;
                    latched1_d   = 1'b0;
                    latched2_d   = 1'b0;
                    turn_count_d = 6'd0;
                    winner_d     = c_WIN_NONE;
                    w_timer_load = 1'b1;
                end
            end

            ST_COLLECT: begin
                if (w_take1) begin
                    action1_d  = act1;
                    latched1_d = 1'b1;
                end
                if (w_take2) begin
                    action2_d  = act2;
                    latched2_d = 1'b1;
                end
                // An offer landing on the expiry cycle is kept; only silent players get await.
                if (latched1_q && latched2_q) begin
                    state_d = ST_APPLY;
                end else if (w_timer_expired) begin
                    if (!latched1_q && !w_take1) begin
                        action1_d = c_ACT_AWAIT;
                    end
                    if (!latched2_q && !w_take2) begin
                        action2_d = c_ACT_AWAIT;
                    end
                    latched1_d = 1'b1;
                    latched2_d = 1'b1;
                    state_d    = ST_APPLY;
                end
            end

            ST_APPLY: begin
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                turn_count_d = w_turn_next;
                if (w_knockout) begin
                    winner_d = ko_winner(health1, health2);
                    state_d  = ST_OVER;
                end else if (w_turn_limit) begin
                    winner_d = points_winner(health1, health2);
                    state_d  = ST_OVER;
                end else begin
                    latched1_d   = 1'b0;
                    latched2_d   = 1'b0;
                    w_timer_load = 1'b1;
                    state_d      = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            latched1_q   <= 1'b0;
            latched2_q   <= 1'b0;
            action1_q    <= c_ACT_AWAIT;
            action2_q    <= c_ACT_AWAIT;
            turn_count_q <= 6'd0;
            winner_q     <= c_WIN_NONE;
        end else begin
            state_q      <= state_d;
            latched1_q   <= latched1_d;
            latched2_q   <= latched2_d;
            action1_q    <= action1_d;
            action2_q    <= action2_d;
            turn_count_q <= turn_count_d;
            winner_q     <= winner_d;
        end
    end

    assign w_timer_enable = (state_q == ST_COLLECT);
    assign w_timer_clear  = (state_q != ST_COLLECT) && !w_timer_load;

    turn_timer #(
        .TURN_TIMEOUT (TURN_TIMEOUT)
    ) u_turn_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .load    (w_timer_load),
        .enable  (w_timer_enable),
        .expired (w_timer_expired)
    );

    assign action1       = action1_q;
    assign action2       = action2_q;
    assign action_enable = (state_q == ST_APPLY);
    assign game_over     = (state_q == ST_OVER);
    assign winner        = winner_q;
    assign turn_count    = turn_count_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_match_controller.sv
// =============================================================================
// Module      : tb_match_controller
// Description : Directed bench with a turn-level reference model for
//               match_controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_match_controller;
    import match_controller_pkg::*;

    localparam int TO = 16;
    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       act1_valid = 1'b0;
    logic [2:0] act1 = 3'b000;
    logic       act2_valid = 1'b0;
    logic [2:0] act2 = 3'b000;
    logic [1:0] health1 = 2'd3;
    logic [1:0] health2 = 2'd3;
    logic       act1_ready;
    logic       act2_ready;
    logic [2:0] action1;
    logic [2:0] action2;
    logic       action_enable;
    logic       game_over;
    logic [1:0] winner;
    logic [5:0] turn_count;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    match_controller #(
        .TURN_TIMEOUT (TO),
        .MAX_TURNS    (MT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .act1_valid    (act1_valid),
        .act1          (act1),
        .act2_valid    (act2_valid),
        .act2          (act2),
        .health1       (health1),
        .health2       (health2),
        .act1_ready    (act1_ready),
        .act2_ready    (act2_ready),
        .action1       (action1),
        .action2       (action2),
        .action_enable (action_enable),
        .game_over     (game_over),
        .winner        (winner),
        .turn_count    (turn_count),
        .busy          (busy)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Turn-level reference: a match is running or not; a running turn is
    // collecting (with a count of elapsed window cycles) or 1/2/3 cycles past it.
    bit         m_run, m_over, m_got1, m_got2;
    int         m_stage, m_ccount, m_turns;
    logic [2:0] m_a1, m_a2;
    logic [1:0] m_win;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_over = 0; m_got1 = 0; m_got2 = 0;
            m_stage = 0; m_ccount = 0; m_turns = 0;
            m_a1 = 3'b010; m_a2 = 3'b010; m_win = 2'b00;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_over = 0; m_win = 2'b00; m_turns = 0;
                m_stage = 0; m_ccount = 0; m_got1 = 0; m_got2 = 0;
            end
        end else begin
            case (m_stage)
                0: begin
                    if (m_got1 && m_got2) begin
                        m_stage = 1;
                    end else begin
                        if (act1_valid && !m_got1) begin m_got1 = 1; m_a1 = act1; end
                        if (act2_valid && !m_got2) begin m_got2 = 1; m_a2 = act2; end
                        m_ccount++;
                        if (m_ccount == TO) begin
                            if (!m_got1) m_a1 = 3'b010;
                            if (!m_got2) m_a2 = 3'b010;
                            m_got1 = 1; m_got2 = 1;
                            m_stage = 1;
                        end
                    end
                end
                1: m_stage = 2;
                2: m_stage = 3;
                default: begin
                    m_turns = (m_turns < 63) ? m_turns + 1 : 63;
                    if (health1 == 0 || health2 == 0) begin
                        m_run = 0; m_over = 1;
                        m_win = (health1 == 0 && health2 == 0) ? 2'b11 : (health1 == 0) ? 2'b10 : 2'b01;
                    end else if (m_turns == MT) begin
                        m_run = 0; m_over = 1;
                        m_win = (health1 > health2) ? 2'b01 : (health2 > health1) ? 2'b10 : 2'b11;
                    end else begin
                        m_stage = 0; m_ccount = 0; m_got1 = 0; m_got2 = 0;
                    end
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #2;
        if (reset) begin
            check("busy", busy, int'(m_run));
            check("act1_ready", act1_ready, int'(m_run && m_stage == 0 && !m_got1));
            check("act2_ready", act2_ready, int'(m_run && m_stage == 0 && !m_got2));
            check("action_enable", action_enable, int'(m_run && m_stage == 1));
            check("game_over", game_over, int'(m_over));
            check("winner", winner, m_win);
            check("turn_count", turn_count, m_turns);
            if (m_run && m_stage != 0) begin
                check("action1", action1, m_a1);
                check("action2", action2, m_a2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready1"}, act1_ready, 0);
        check({tag, "_ready2"}, act2_ready, 0);
        check({tag, "_enable"}, action_enable, 0);
        check({tag, "_action1"}, action1, 2);
        check({tag, "_action2"}, action2, 2);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_winner"}, winner, 0);
        check({tag, "_turn_count"}, turn_count, 0);
    endtask

    int n;
    int pulses[$];
    int ready_hits;
    int en_seen;
    int busy_seen;

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Both offers in the same cycle; strobe two cycles later.
        pulse_start();
        check("c0_ready1", act1_ready, 1);
        act1_valid = 1; act1 = 3'b110; act2_valid = 1; act2 = 3'b000;
        @(negedge clk); act1_valid = 0; act2_valid = 0;
        check("c1_ready1", act1_ready, 0);
        check("c1_ready2", act2_ready, 0);
        check("c1_enable", action_enable, 0);
        @(negedge clk);
        check("apply_enable", action_enable, 1);
        check("apply_action1", action1, 6);
        check("apply_action2", action2, 0);
        @(negedge clk);
        check("settle_enable", action_enable, 0);
        check("settle_action1", action1, 6);
        @(negedge clk);
        check("check_turns", turn_count, 0);
        @(negedge clk);
        check("turn1_count", turn_count, 1);
        check("turn1_ready1", act1_ready, 1);

        // Only player 1 offers; player 2 defaults at the window end. Mid-turn start ignored.
        act1_valid = 1; act1 = 3'b101;
        @(negedge clk); act1_valid = 0;
        n = 1;
        while (!action_enable && n < 40) begin
            start = (n == 5);
            @(negedge clk); n++;
        end
        start = 0;
        check("timeout_apply_cycle", n, 16);
        check("timeout_action1", action1, 5);
        check("timeout_action2", action2, 2);
        repeat (3) @(negedge clk);
        check("turn2_count", turn_count, 2);

        // Valids held high through the last two turns at equal health.
        act1_valid = 1; act1 = 3'b111; act2_valid = 1; act2 = 3'b100;
        ready_hits = 0;
        for (int i = 0; i < 15; i++) begin
            if (action_enable) pulses.push_back(i);
            if (act1_ready) ready_hits++;
            @(negedge clk);
        end
        act1_valid = 0; act2_valid = 0;
        check("held_pulse_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            check("held_pulse_first", pulses[0], 2);
            check("held_pulse_spacing", pulses[1] - pulses[0], 5);
        end
        check("held_latch_count", ready_hits, 2);
        check("draw_game_over", game_over, 1);
        check("draw_winner", winner, 3);
        check("draw_turns", turn_count, 4);
        check("draw_busy", busy, 0);

        // Restart from OVER, then win on points for player 2.
        health1 = 2'd2; health2 = 2'd3;
        pulse_start();
        check("restart_game_over", game_over, 0);
        check("restart_winner", winner, 0);
        check("restart_turns", turn_count, 0);
        check("restart_busy", busy, 1);
        act1_valid = 1; act1 = 3'b001; act2_valid = 1; act2 = 3'b011;
        n = 0;
        while (!game_over && n < 40) begin @(negedge clk); n++; end
        act1_valid = 0; act2_valid = 0;
        check("points_cycles", n, 20);
        check("points_winner", winner, 2);
        check("points_turns", turn_count, 4);

        // Knockout of player 2 in the first turn.
        health1 = 2'd3; health2 = 2'd3;
        pulse_start();
        act1_valid = 1; act1 = 3'b000; act2_valid = 1; act2 = 3'b001;
        health2 = 2'd0;
        @(negedge clk); act1_valid = 0; act2_valid = 0;
        n = 0;
        while (!game_over && n < 40) begin @(negedge clk); n++; end
        check("ko_game_over", game_over, 1);
        check("ko_winner", winner, 1);
        check("ko_turns", turn_count, 1);
        health2 = 2'd3;
        pulse_start();
        check("ko_restart_game_over", game_over, 0);
        check("ko_restart_winner", winner, 0);
        check("ko_restart_turns", turn_count, 0);

        // Reset after one latch: no strobe, reset values, stays idle.
        act1_valid = 1; act1 = 3'b011;
        @(negedge clk); act1_valid = 0;
        check("pre_rst_ready1", act1_ready, 0);
        check("pre_rst_ready2", act2_ready, 1);
        #1 reset = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        en_seen = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (action_enable) en_seen++;
            if (busy) busy_seen++;
        end
        check("post_rst_enable", en_seen, 0);
        check("post_rst_busy", busy_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
